// File: rtl/mem_pkg.sv
// Shared types and helpers for the M-stage data-memory bus interface.
package mem_pkg;

  typedef enum logic [1:0] {
    MT_BYTE  = 2'b00,
    MT_HALF  = 2'b01,
    MT_WORD  = 2'b10,
    MT_DWORD = 2'b11
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  // 8-lane enable mask; narrower buses keep only the low lanes.
  function automatic logic [7:0] be_gen(mem_type_e mt, logic [2:0] off);
    logic [7:0] base;
    unique case (mt)
      MT_BYTE:  base = 8'h01;
      MT_HALF:  base = 8'h03;
      MT_WORD:  base = 8'h0F;
      MT_DWORD: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/mem_stage_bus_load_extend.sv
// Load lane select plus sign/zero extension of the raw bus word.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]              rdata_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    off_i,
  input  logic [1:0]                         type_i,
  input  logic                               sign_i,
  output logic [DATA_WIDTH-1:0]              data_o
);

  localparam int IW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sh;
  logic [IW-1:0]         msb;
  logic                  fill;
  int                    nbits;

  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    unique case (mem_type_e'(type_i))
      MT_BYTE: nbits = 8;
      MT_HALF: nbits = 16;
      MT_WORD: nbits = 32;
      default: nbits = DATA_WIDTH;
    endcase
    msb    = IW'(nbits - 1);
    fill   = sign_i & sh[msb];
    data_o = sh;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= nbits) data_o[i] = fill;
    end
  end

endmodule

// File: rtl/mem_stage_bus.sv
// Pipeline M stage driving a req/gnt/rvalid data bus and the M/W register.
module mem_stage_bus
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ValidM_i,
  input  logic                    MemRead_i,
  input  logic                    MemWrite_i,
  input  logic [1:0]              MemType_i,
  input  logic                    MemSign_i,
  input  logic [DATA_WIDTH-1:0]   ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]   WriteDataM_i,
  input  logic [DATA_WIDTH-1:0]   PCPlus4M_i,
  input  logic [4:0]              RdM_i,
  input  logic                    FlushM_i,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [DATA_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  output logic                    StallM_o,
  output logic                    MisalignedM_o,
  output logic                    ValidW_o,
  output logic [DATA_WIDTH-1:0]   ReadDataW_o,
  output logic [DATA_WIDTH-1:0]   ALUResultW_o,
  output logic [DATA_WIDTH-1:0]   PCPlus4W_o,
  output logic [4:0]              RdW_o,
  output logic                    BusErrW_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LW     = $clog2(NBYTES);
  localparam int CW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  flush_q, flush_d;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic [NBYTES-1:0]     be_q;

  logic                  valid_w_q, err_w_q;
  logic [DATA_WIDTH-1:0] rdata_w_q, alu_w_q, pc_w_q;
  logic [4:0]            rd_w_q;

  logic                  mem, mis, start, busy;
  logic                  in_req, done, tmo, abort;
  logic [LW-1:0]         off;
  mem_type_e             mt;
  logic [NBYTES-1:0]     be_now;
  logic [DATA_WIDTH-1:0] lane_addr, lane_wdata, ext;

  assign off        = ALUResultM_i[LW-1:0];
  assign mt         = mem_type_e'(MemType_i);
  assign mem        = ValidM_i & (MemRead_i | MemWrite_i);
  assign be_now     = NBYTES'(be_gen(mt, 3'(off)));
  assign lane_addr  = {ALUResultM_i[DATA_WIDTH-1:LW], {LW{1'b0}}};
  assign lane_wdata = WriteDataM_i << {off, 3'b000};

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      mt == MT_HALF:  mis = ALUResultM_i[0];
      mt == MT_WORD:  mis = |ALUResultM_i[1:0];
      mt == MT_DWORD: mis = (DATA_WIDTH == 32) | (|ALUResultM_i[2:0]);
      default:        mis = 1'b0;
    endcase
  end

  assign MisalignedM_o = mem & mis;

  assign busy   = state_q != S_IDLE;
  assign in_req = state_q == S_REQ;
  assign start  = ~busy & mem & ~mis & ~FlushM_i;
  // gnt and rvalid together in REQ finish the access in one cycle
  assign done   = bus_rvalid_i & ((state_q == S_WAIT) | (in_req & bus_gnt_i));
  assign tmo    = busy & (cnt_q == TO_LAST);
  assign abort  = tmo & ~done;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ext (
    .rdata_i (bus_rdata_i),
    .off_i   (off),
    .type_i  (MemType_i),
    .sign_i  (MemSign_i),
    .data_o  (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = bus_gnt_i ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (done | abort)   state_d = S_IDLE;
        else if (bus_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done | abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    StallM_o    = start | (busy & ~done & ~abort);
    if (start) begin
      bus_req_o   = 1'b1;
      bus_we_o    = MemWrite_i;
      bus_addr_o  = lane_addr;
      bus_be_o    = be_now;
      bus_wdata_o = lane_wdata;
    end else if (in_req & ~abort) begin
      bus_req_o   = 1'b1;
      bus_we_o    = we_q;
      bus_addr_o  = addr_q;
      bus_be_o    = be_q;
      bus_wdata_o = wdata_q;
    end
  end

  assign cnt_d   = (busy & (state_d != S_IDLE)) ? cnt_q + 1'b1 : '0;
  assign flush_d = StallM_o & (flush_q | FlushM_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      if (start) begin
        we_q    <= MemWrite_i;
        addr_q  <= lane_addr;
        be_q    <= be_now;
        wdata_q <= lane_wdata;
      end
    end
  end

  // While stalled only a bubble is written; the rest of W holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_w_q <= 1'b0;
      err_w_q   <= 1'b0;
      rdata_w_q <= '0;
      alu_w_q   <= '0;
      pc_w_q    <= '0;
      rd_w_q    <= '0;
    end else if (StallM_o) begin
      valid_w_q <= 1'b0;
    end else begin
      valid_w_q <= ValidM_i & ~MisalignedM_o & ~FlushM_i & ~flush_q & ~abort;
      err_w_q   <= abort;
      rdata_w_q <= (done & MemRead_i) ? ext : '0;
      alu_w_q   <= ALUResultM_i;
      pc_w_q    <= PCPlus4M_i;
      rd_w_q    <= RdM_i;
    end
  end

  assign ValidW_o     = valid_w_q;
  assign BusErrW_o    = err_w_q;
  assign ReadDataW_o  = rdata_w_q;
  assign ALUResultW_o = alu_w_q;
  assign PCPlus4W_o   = pc_w_q;
  assign RdW_o        = rd_w_q;

endmodule
